// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the memory-map RX data register.
// Latency: a pushed byte is visible on rd_data one cycle after its rx_valid edge; rd_data is first-word fall-through.
// Backpressure: none towards the receiver; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int THRESH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_valid,
    input  logic [DATA_WIDTH-1:0]        rx_byte,
    input  logic                         rx_par_err,
    input  logic                         rd_en,
    input  logic                         clr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_par_err,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         rx_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // One stored frame: payload plus the parity status captured with it.
    typedef struct packed {
        logic                  par_err;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            ovf;

    logic            is_empty;
    logic            is_full;
    logic            do_pop;
    logic            do_push;
    logic            drop;
    logic [CW-1:0]   cnt_nxt;
    entry_t          wr_entry;
    entry_t          head;

    // Occupancy flags; full/empty come only from the separate count so pointer equality never needs disambiguation.
    always_comb begin
        is_empty = (cnt == '0);
        is_full  = (cnt == DEPTH_C);
    end

    // Push/pop qualification: a full FIFO still accepts a byte when the head leaves in the same cycle.
    always_comb begin
        do_pop   = rd_en & ~is_empty;
        do_push  = rx_valid & (~is_full | do_pop);
        drop     = rx_valid & is_full & ~do_pop;
        wr_entry = '{par_err: rx_par_err, dat: rx_byte};
    end

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        cnt_nxt = cnt;
        unique case ({do_push, do_pop})
            2'b10:   cnt_nxt = cnt + CNT_ONE;
            2'b01:   cnt_nxt = cnt - CNT_ONE;
            default: cnt_nxt = cnt;
        endcase
    end

    // Pointer, count and sticky overflow state; clr wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            cnt <= cnt_nxt;
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage write; the array carries no reset since contents are only observed through count.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Head entry fall-through, forced to zero while empty so stale storage never leaks to the bus.
    always_comb begin
        head = '0;
        if (!is_empty) begin
            head = mem[rd_ptr];
        end
    end

    assign rd_data    = head.dat;
    assign rd_par_err = head.par_err;
    assign empty      = is_empty;
    assign full       = is_full;
    assign count      = cnt;
    assign overflow   = ovf;
    assign rx_irq     = (cnt >= THRESH_C);

    // Occupancy can never exceed the storage size.
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst) cnt <= DEPTH_C);

    // The pointer gap always matches the tracked occupancy (modulo depth).
    a_ptr_gap: assert property (@(posedge clk) disable iff (!rst)
        (AW'(wr_ptr - rd_ptr) == AW'(cnt)));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus randomized traffic against a queue model.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled before and 1 unit after the next edge.
// Backpressure: the model drops pushes into a full queue without a same-cycle pop and latches overflow.
module tb_uart_rx_fifo;

    localparam int DW     = 8;
    localparam int DEPTH  = 8;
    localparam int THRESH = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [DW-1:0]     rx_byte;
    logic              rx_par_err;
    logic              rd_en;
    logic              clr;
    logic [DW-1:0]     rd_data;
    logic              rd_par_err;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              rx_irq;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of {par_err, byte} plus the sticky overflow flag.
    logic [DW:0] model_q [$];
    logic        model_ovf;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .THRESH     (THRESH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_par_err (rx_par_err),
        .rd_en      (rd_en),
        .clr        (clr),
        .rd_data    (rd_data),
        .rd_par_err (rd_par_err),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .rx_irq     (rx_irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against what the model says is stored right now.
    task automatic check_outputs(input string tag);
        logic [DW:0] exp_head;
        int          sz;
        sz       = model_q.size();
        exp_head = (sz == 0) ? '0 : model_q[0];
        check_eq({tag, ".count"},      32'(count),      32'(sz));
        check_eq({tag, ".empty"},      32'(empty),      32'(sz == 0));
        check_eq({tag, ".full"},       32'(full),       32'(sz == DEPTH));
        check_eq({tag, ".rx_irq"},     32'(rx_irq),     32'(sz >= THRESH));
        check_eq({tag, ".overflow"},   32'(overflow),   32'(model_ovf));
        check_eq({tag, ".rd_data"},    32'(rd_data),    32'(exp_head[DW-1:0]));
        check_eq({tag, ".rd_par_err"}, 32'(rd_par_err), 32'(exp_head[DW]));
    endtask

    // One clock of stimulus; returns the head seen on the bus just before the edge.
    task automatic step(input string tag, input logic rv, input logic [DW-1:0] b, input logic pe,
                        input logic rd, input logic c, output logic [DW:0] seen);
        logic pop;
        rx_valid   = rv;
        rx_byte    = b;
        rx_par_err = pe;
        rd_en      = rd;
        clr        = c;
        #1;
        check_outputs({tag, ".pre"});
        seen = {rd_par_err, rd_data};
        @(posedge clk);
        #1;
        if (c) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            pop = rd && (model_q.size() > 0);
            if (rv && !(model_q.size() < DEPTH || pop)) model_ovf = 1'b1;
            if (rv && (model_q.size() < DEPTH || pop)) begin
                if (pop) void'(model_q.pop_front());
                model_q.push_back({pe, b});
            end else if (pop) begin
                void'(model_q.pop_front());
            end
        end
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        clr      = 1'b0;
        check_outputs({tag, ".post"});
    endtask

    task automatic push(input string tag, input logic [DW-1:0] b, input logic pe);
        logic [DW:0] s;
        step(tag, 1'b1, b, pe, 1'b0, 1'b0, s);
    endtask

    task automatic pop_expect(input string tag, input logic [DW-1:0] b);
        logic [DW:0] s;
        step(tag, 1'b0, '0, 1'b0, 1'b1, 1'b0, s);
        check_eq({tag, ".data"}, 32'(s[DW-1:0]), 32'(b));
    endtask

    task automatic do_clr(input string tag);
        logic [DW:0] s;
        step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b1, s);
    endtask

    initial begin
        logic [DW:0]   s;
        logic [DW-1:0] exp_list [8];
        int            p_push;
        int            p_pop;

        model_ovf  = 1'b0;
        rst        = 1'b0;
        rx_valid   = 1'b0;
        rx_byte    = '0;
        rx_par_err = 1'b0;
        rd_en      = 1'b0;
        clr        = 1'b0;

        // Reset state.
        #12;
        check_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Order.
        push("ord", 8'h11, 1'b0);
        push("ord", 8'h22, 1'b0);
        push("ord", 8'h33, 1'b0);
        pop_expect("ord0", 8'h11);
        pop_expect("ord1", 8'h22);
        pop_expect("ord2", 8'h33);
        check_eq("ord.empty", 32'(empty), 32'd1);
        check_eq("ord.rd_data", 32'(rd_data), 32'h0);

        // Fill, overflow, wrap.
        for (int i = 0; i < 8; i++) begin
            push("fill", 8'hA0 + 8'(i), 1'b0);
            if (i >= 3) check_eq("fill.irq", 32'(rx_irq), 32'd1);
            else        check_eq("fill.irq_lo", 32'(rx_irq), 32'd0);
        end
        check_eq("fill.full", 32'(full), 32'd1);
        push("ovf", 8'hFF, 1'b0);
        check_eq("ovf.flag", 32'(overflow), 32'd1);
        check_eq("ovf.count", 32'(count), 32'd8);
        pop_expect("wrap.p0", 8'hA0);
        pop_expect("wrap.p1", 8'hA1);
        pop_expect("wrap.p2", 8'hA2);
        for (int i = 0; i < 3; i++) push("wrap.push", 8'hB0 + 8'(i), 1'b0);
        for (int i = 0; i < 5; i++) exp_list[i] = 8'hA3 + 8'(i);
        for (int i = 0; i < 3; i++) exp_list[5 + i] = 8'hB0 + 8'(i);
        for (int i = 0; i < 8; i++) pop_expect("wrap.drain", exp_list[i]);
        check_eq("wrap.empty", 32'(empty), 32'd1);
        check_eq("wrap.ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous push and pop: full, then empty.
        do_clr("sim.clr");
        for (int i = 0; i < 8; i++) push("sim.fill", 8'(8'h40 + i), 1'b0);
        step("sim.full", 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, s);
        check_eq("sim.full.head", 32'(s[DW-1:0]), 32'h40);
        check_eq("sim.full.count", 32'(count), 32'd8);
        check_eq("sim.full.ovf", 32'(overflow), 32'd0);
        do_clr("sim.clr2");
        step("sim.empty", 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, s);
        check_eq("sim.empty.count", 32'(count), 32'd1);
        check_eq("sim.empty.data", 32'(rd_data), 32'h5A);

        // Parity and clear.
        do_clr("par.clr");
        push("par", 8'h3C, 1'b1);
        check_eq("par.flag", 32'(rd_par_err), 32'd1);
        check_eq("par.data", 32'(rd_data), 32'h3C);
        for (int i = 0; i < 8; i++) push("par.fill", 8'(i), 1'b0);
        check_eq("par.ovf", 32'(overflow), 32'd1);
        step("clr.push", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, s);
        check_eq("clr.count", 32'(count), 32'd0);
        check_eq("clr.ovf", 32'(overflow), 32'd0);
        check_eq("clr.rd_data", 32'(rd_data), 32'h0);

        // Asynchronous reset mid-stream with 3 entries stored and a frame in flight.
        push("rst.fill", 8'h91, 1'b0);
        push("rst.fill", 8'h92, 1'b1);
        push("rst.fill", 8'h93, 1'b0);
        #2;
        rx_valid = 1'b1;
        rx_byte  = 8'hEE;
        rst      = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        check_eq("rst.empty", 32'(empty), 32'd1);
        check_eq("rst.count", 32'(count), 32'd0);
        check_eq("rst.rd_data", 32'(rd_data), 32'h0);
        check_eq("rst.overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #3;
        rx_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rst.after");

        // Randomized traffic with phases biased towards filling and draining.
        for (int ph = 0; ph < 12; ph++) begin
            case (ph % 3)
                0:       begin p_push = 80; p_pop = 25; end
                1:       begin p_push = 25; p_pop = 80; end
                default: begin p_push = 55; p_pop = 55; end
            endcase
            for (int n = 0; n < 150; n++) begin
                step("rnd",
                     ($urandom_range(99) < p_push),
                     8'($urandom),
                     1'($urandom),
                     ($urandom_range(99) < p_pop),
                     ($urandom_range(199) == 0),
                     s);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
